pe_priority_seq: RTL and testbench

//  Parametrised sequential successor to the pixel priority evaluator. Per pixel it accepts
//  NUM_BG+1 layer candidates serially (OBJ, then BG0..BG(NUM_BG-1)) and tracks the top two

---
 rtl/pe_pkg.sv | 29 ++
 rtl/pe_rank_cmp.sv | 27 ++
 rtl/pe_priority_seq.sv | 195 +++++++++++++++++++
 tb/tb_pe_priority_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the sequential pixel priority evaluator: layer-word field map,
// backdrop constant, sequencer states and the palette halfword selector.
package pe_pkg;

    localparam int PRIO_HI    = 19;
    localparam int PRIO_LO    = 18;
    localparam int OBJ_BIT    = 17;
    localparam int OPAQUE_BIT = 15;
    localparam int MODE_HI    = 14;
    localparam int MODE_LO    = 13;
    localparam int IDX_HI     = 8;

    localparam logic [1:0]  MODE_OBJ_WIN = 2'b10;
    localparam logic [19:0] BACKDROP     = 20'h0_8000;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        F0,
        F1,
        OUT
    } pe_seq_state_t;

    // Palette words pack two BGR555 entries; bit 15 of each halfword is dropped.
    function automatic logic [14:0] pal_half(input logic [31:0] rdata, input logic odd);
        return odd ? rdata[30:16] : rdata[14:0];
    endfunction

endpackage

// File: rtl/pe_rank_cmp.sv
// Combinational rank comparator: does a candidate displace a reference entry?
// Keys are {prio[1:0], is_obj}; a reference flagged as backdrop loses to any visible candidate.
module pe_rank_cmp (
    input  logic [2:0] i_cand_key,
    input  logic       i_cand_vis,
    input  logic [2:0] i_ref_key,
    input  logic       i_ref_bd,
    output logic       o_outranks
);

    logic [1:0] w_cand_prio;
    logic [1:0] w_ref_prio;
    logic       w_cand_obj;
    logic       w_ref_obj;

    assign w_cand_prio = i_cand_key[2:1];
    assign w_cand_obj  = i_cand_key[0];
    assign w_ref_prio  = i_ref_key[2:1];
    assign w_ref_obj   = i_ref_key[0];

    // Equal-priority BG never displaces, so earlier (lower-numbered) BGs keep their slot.
    assign o_outranks = i_cand_vis &&
                        (i_ref_bd ||
                         (w_cand_prio < w_ref_prio) ||
                         ((w_cand_prio == w_ref_prio) && w_cand_obj && !w_ref_obj));

endmodule

// File: rtl/pe_priority_seq.sv
// Serial per-pixel priority evaluator: ranks OBJ + NUM_BG candidates into top/second slots,
// fetches both colours from palette RAM (coalescing same-word reads) and hands off under valid/ready.
module pe_priority_seq
    import pe_pkg::*;
#(
    parameter int NUM_BG  = 4,
    parameter int LAYER_W = 20,
    parameter int PAL_AW  = 8
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LAYER_W-1:0] in_layer,
    input  logic [NUM_BG:0]    in_mask,
    input  logic [4:0]         in_effects,
    output logic               pram_req,
    output logic [PAL_AW-1:0]  pram_addr,
    input  logic               pram_ack,
    input  logic [31:0]        pram_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [14:0]        color0,
    output logic [14:0]        color1,
    output logic [LAYER_W-1:0] layer0,
    output logic [LAYER_W-1:0] layer1,
    output logic [4:0]         effects
);

    localparam int                CNT_W     = $clog2(NUM_BG + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NUM_BG);

    pe_seq_state_t      r_state;
    pe_seq_state_t      w_next;
    logic [CNT_W-1:0]   r_beat;
    logic [LAYER_W-1:0] r_top;
    logic [LAYER_W-1:0] r_bot;
    logic               r_top_bd;
    logic               r_bot_bd;
    logic [NUM_BG:0]    r_mask;
    logic [4:0]         r_eff;
    logic [14:0]        r_col0;

    logic               w_first;
    logic               w_accept;
    logic [CNT_W-1:0]   w_bg_sel;
    logic               w_mask_bit;
    logic               w_cand_vis;
    logic [LAYER_W-1:0] w_top_ref;
    logic [LAYER_W-1:0] w_bot_ref;
    logic               w_top_ref_bd;
    logic               w_bot_ref_bd;
    logic               w_beats_top;
    logic               w_beats_bot;
    logic [LAYER_W-1:0] w_top_new;
    logic [LAYER_W-1:0] w_bot_new;
    logic               w_top_new_bd;
    logic               w_bot_new_bd;
    logic               w_coalesce;
    logic [14:0]        w_top_half;
    logic [14:0]        w_bot_half;
    logic               w_load_out;
    logic               w_unused_rdata;

    // The first beat ranks against a freshly preloaded backdrop rather than last pixel's slots.
    assign w_first      = (r_state == IDLE);
    assign w_accept     = in_valid && in_ready;
    assign w_bg_sel     = r_beat - CNT_W'(1);
    assign w_mask_bit   = w_first ? in_mask[NUM_BG] : r_mask[w_bg_sel];
    assign w_cand_vis   = in_layer[OPAQUE_BIT] && w_mask_bit &&
                          !(in_layer[OBJ_BIT] && (in_layer[MODE_HI:MODE_LO] == MODE_OBJ_WIN));
    assign w_top_ref    = w_first ? BACKDROP : r_top;
    assign w_bot_ref    = w_first ? BACKDROP : r_bot;
    assign w_top_ref_bd = w_first ? 1'b1 : r_top_bd;
    assign w_bot_ref_bd = w_first ? 1'b1 : r_bot_bd;

    pe_rank_cmp u_cmp_top (
        .i_cand_key (in_layer[PRIO_HI:OBJ_BIT]),
        .i_cand_vis (w_cand_vis),
        .i_ref_key  (w_top_ref[PRIO_HI:OBJ_BIT]),
        .i_ref_bd   (w_top_ref_bd),
        .o_outranks (w_beats_top)
    );

    pe_rank_cmp u_cmp_bot (
        .i_cand_key (in_layer[PRIO_HI:OBJ_BIT]),
        .i_cand_vis (w_cand_vis),
        .i_ref_key  (w_bot_ref[PRIO_HI:OBJ_BIT]),
        .i_ref_bd   (w_bot_ref_bd),
        .o_outranks (w_beats_bot)
    );

    // NOTE: every combinational output gets a default before any branch, so no latch can form.
    always_comb begin
        w_top_new    = w_top_ref;
        w_top_new_bd = w_top_ref_bd;
        w_bot_new    = w_bot_ref;
        w_bot_new_bd = w_bot_ref_bd;
        if (w_beats_top) begin
            w_top_new    = in_layer;
            w_top_new_bd = 1'b0;
            w_bot_new    = w_top_ref;
            w_bot_new_bd = w_top_ref_bd;
        end else if (w_beats_bot) begin
            w_bot_new    = in_layer;
            w_bot_new_bd = 1'b0;
        end
    end

    assign w_coalesce     = (r_top[IDX_HI:1] == r_bot[IDX_HI:1]);
    assign w_top_half     = pal_half(pram_rdata, r_top[0]);
    assign w_bot_half     = pal_half(pram_rdata, r_bot[0]);
    assign pram_addr      = (r_state == F1) ? PAL_AW'(r_bot[IDX_HI:1]) : PAL_AW'(r_top[IDX_HI:1]);
    assign w_unused_rdata = ^{pram_rdata[31], pram_rdata[15]};

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        pram_req  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && (r_beat == LAST_BEAT)) w_next = F0;
            end
            F0: begin
                pram_req = 1'b1;
                if (pram_ack) w_next = w_coalesce ? OUT : F1;
            end
            F1: begin
                pram_req = 1'b1;
                if (pram_ack) w_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Output registers load only on the transition into OUT, so they hold across backpressure.
    assign w_load_out = (w_next == OUT) && (r_state != OUT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_beat   <= '0;
            r_top    <= '0;
            r_bot    <= '0;
            r_top_bd <= 1'b0;
            r_bot_bd <= 1'b0;
            r_mask   <= '0;
            r_eff    <= '0;
            r_col0   <= '0;
            color0   <= '0;
            color1   <= '0;
            layer0   <= '0;
            layer1   <= '0;
            effects  <= '0;
        end else begin
            if (w_accept) begin
                r_top    <= w_top_new;
                r_bot    <= w_bot_new;
                r_top_bd <= w_top_new_bd;
                r_bot_bd <= w_bot_new_bd;
                if (w_first) begin
                    r_mask <= in_mask;
                    r_eff  <= in_effects;
                    r_beat <= CNT_W'(1);
                end else begin
                    r_beat <= r_beat + CNT_W'(1);
                end
            end
            if ((r_state == F0) && pram_ack) r_col0 <= w_top_half;
            if (w_load_out) begin
                color0  <= (r_state == F0) ? w_top_half : r_col0;
                color1  <= w_bot_half;
                layer0  <= r_top;
                layer1  <= r_bot;
                effects <= r_eff;
            end
        end
    end

endmodule

// File: tb/tb_pe_priority_seq.sv
// Directed self-checking bench for pe_priority_seq with a behavioural palette RAM responder.
module tb_pe_priority_seq;

    localparam int NUM_BG  = 4;
    localparam int LAYER_W = 20;
    localparam int PAL_AW  = 8;

    logic               clk = 1'b0;
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic [LAYER_W-1:0] in_layer;
    logic [NUM_BG:0]    in_mask;
    logic [4:0]         in_effects;
    logic               pram_req;
    logic [PAL_AW-1:0]  pram_addr;
    logic               pram_ack   = 1'b0;
    logic [31:0]        pram_rdata = 32'h0;
    logic               out_valid;
    logic               out_ready;
    logic [14:0]        color0;
    logic [14:0]        color1;
    logic [LAYER_W-1:0] layer0;
    logic [LAYER_W-1:0] layer1;
    logic [4:0]         effects;

    logic [31:0] pram [256];
    int          wait_cfg   = 0;
    int          wcnt       = 0;
    int          inject_req = 0;
    int          inject_seen = 0;
    int          n_ack      = 0;
    logic [7:0]  last_ack_addr = 8'h0;
    int          n_cmp      = 0;
    int          n_bad      = 0;

    always #5 clk = ~clk;

    pe_priority_seq #(.NUM_BG(NUM_BG), .LAYER_W(LAYER_W), .PAL_AW(PAL_AW)) dut (
        .clk        (clk),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_layer   (in_layer),
        .in_mask    (in_mask),
        .in_effects (in_effects),
        .pram_req   (pram_req),
        .pram_addr  (pram_addr),
        .pram_ack   (pram_ack),
        .pram_rdata (pram_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .color0     (color0),
        .color1     (color1),
        .layer0     (layer0),
        .layer1     (layer1),
        .effects    (effects)
    );

    // Palette responder: acks after wait_cfg idle cycles; can also fire one unsolicited ack.
    always @(negedge clk) begin
        if (pram_ack) wcnt = 0;
        pram_ack = 1'b0;
        if (inject_req != inject_seen) begin
            inject_seen = inject_req;
            pram_ack    = 1'b1;
            pram_rdata  = 32'hFFFF_FFFF;
        end else if (pram_req) begin
            if (wcnt >= wait_cfg) begin
                pram_ack   = 1'b1;
                pram_rdata = pram[pram_addr];
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(posedge clk) begin
        if (pram_req && pram_ack) begin
            n_ack++;
            last_ack_addr = pram_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] mk(input logic [1:0] prio, input logic obj, input logic opq,
                                       input logic [1:0] mode, input logic [8:0] idx);
        return {prio, obj, 1'b0, opq, mode, 4'b0000, idx};
    endfunction

    task automatic send_beat(input logic [19:0] layer, input logic [4:0] mask, input logic [4:0] eff);
        int n;
        n          = 0;
        in_valid   = 1'b1;
        in_layer   = layer;
        in_mask    = mask;
        in_effects = eff;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("beat_accept", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_pixel(input logic [4:0][19:0] lay, input logic [4:0] mask, input logic [4:0] eff);
        for (int i = 0; i <= NUM_BG; i++) send_beat(lay[i], mask, eff);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_seen", out_valid, 1'b1);
    endtask

    task automatic check_out(input string tag, input logic [19:0] l0, input logic [19:0] l1,
                             input logic [14:0] c0, input logic [14:0] c1, input logic [4:0] eff);
        check({tag, ".layer0"},  layer0,  l0);
        check({tag, ".layer1"},  layer1,  l1);
        check({tag, ".color0"},  color0,  c0);
        check({tag, ".color1"},  color1,  c1);
        check({tag, ".effects"}, effects, eff);
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0][19:0] px1, px2a, px2b, px3, px4, px4b;
        int lat, a0, n;

        for (int i = 0; i < 256; i++) pram[i] = 32'h0;
        pram[8'h00] = 32'h7FFF_C321;
        pram[8'h09] = 32'h7C00_001F;
        pram[8'h82] = 32'h03E0_1234;
        pram[8'h18] = 32'h1111_2222;
        pram[8'h20] = 32'hD555_E666;
        pram[8'h10] = 32'hABCD_9876;
        pram[8'h30] = 32'h0000_0ABC;

        // Packed order is {BG3, BG2, BG1, BG0, OBJ}.
        px1  = {20'h0, 20'h0, mk(2'd0, 1'b0, 1'b0, 2'b00, 9'h033), mk(2'd0, 1'b0, 1'b1, 2'b00, 9'h012),
                mk(2'd1, 1'b1, 1'b1, 2'b00, 9'h105)};
        px2a = {20'h0, mk(2'd2, 1'b0, 1'b1, 2'b00, 9'h030), 20'h0, 20'h0,
                mk(2'd2, 1'b1, 1'b1, 2'b00, 9'h104)};
        px2b = {mk(2'd2, 1'b0, 1'b1, 2'b00, 9'h041), 20'h0, mk(2'd2, 1'b0, 1'b1, 2'b00, 9'h040),
                20'h0, 20'h0};
        px3  = {20'h0, 20'h0, mk(2'd2, 1'b0, 1'b1, 2'b00, 9'h021), mk(2'd1, 1'b0, 1'b1, 2'b00, 9'h020),
                20'h0};
        px4  = {mk(2'd0, 1'b0, 1'b1, 2'b00, 9'h011), mk(2'd1, 1'b0, 1'b1, 2'b00, 9'h022),
                mk(2'd2, 1'b0, 1'b1, 2'b00, 9'h033), mk(2'd3, 1'b0, 1'b1, 2'b00, 9'h044),
                mk(2'd0, 1'b1, 1'b1, 2'b00, 9'h155)};
        px4b = {20'h0, mk(2'd0, 1'b0, 1'b1, 2'b00, 9'h050), mk(2'd3, 1'b0, 1'b1, 2'b00, 9'h060),
                20'h0, mk(2'd0, 1'b1, 1'b1, 2'b10, 9'h1FF)};

        clear      = 1'b1;
        in_valid   = 1'b0;
        in_layer   = '0;
        in_mask    = '0;
        in_effects = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check("rst.in_ready",  in_ready,  1'b1);
        check("rst.pram_req",  pram_req,  1'b0);
        check("rst.out_valid", out_valid, 1'b0);
        check_out("rst", 20'h0, 20'h0, 15'h0, 15'h0, 5'h0);

        // Basic two-read pixel: BG0 prio0 on top, OBJ prio1 second.
        a0 = n_ack;
        send_pixel(px1, 5'h1F, 5'h15);
        wait_out(lat);
        check("t1.latency", lat, 3);
        check_out("t1", 20'h08012, 20'h68105, 15'h001F, 15'h03E0, 5'h15);
        check("t1.reads", n_ack - a0, 2);
        accept_out();

        // Equal-priority ties: OBJ over BG, then the earlier BG over the later one.
        send_pixel(px2a, 5'h1F, 5'h01);
        wait_out(lat);
        check_out("t2a", 20'hA8104, 20'h88030, 15'h1234, 15'h2222, 5'h01);
        accept_out();
        send_pixel(px2b, 5'h1F, 5'h02);
        wait_out(lat);
        check_out("t2b", 20'h88040, 20'h88041, 15'h6666, 15'h5555, 5'h02);
        accept_out();

        // Both entries in one palette word: single handshake and shorter latency.
        a0 = n_ack;
        send_pixel(px3, 5'h1F, 5'h03);
        wait_out(lat);
        check("t3.latency", lat, 2);
        check("t3.reads", n_ack - a0, 1);
        check("t3.addr", last_ack_addr, 8'h10);
        check_out("t3", 20'h48020, 20'h88021, 15'h1876, 15'h2BCD, 5'h03);
        accept_out();

        // Everything masked off: backdrop in both slots.
        a0 = n_ack;
        send_pixel(px4, 5'h00, 5'h1F);
        wait_out(lat);
        check("t4.reads", n_ack - a0, 1);
        check_out("t4", 20'h08000, 20'h08000, 15'h4321, 15'h4321, 5'h1F);
        accept_out();

        // OBJ-window OBJ and masked BG2 drop out; a prio-3 BG still beats the backdrop.
        send_pixel(px4b, 5'b11011, 5'h04);
        wait_out(lat);
        check_out("t4b", 20'hC8060, 20'h08000, 15'h0ABC, 15'h4321, 5'h04);
        accept_out();

        // Abort during the second read with a slow palette, then a stray ack while idle.
        wait_cfg = 3;
        send_pixel(px1, 5'h1F, 5'h15);
        n = 0;
        while (!(pram_req && pram_addr == 8'h82) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5.in_f1", pram_req && (pram_addr == 8'h82), 1'b1);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check("t5.req_drop",  pram_req,  1'b0);
        check("t5.in_ready",  in_ready,  1'b1);
        check("t5.out_valid", out_valid, 1'b0);
        check("t5.layer0",    layer0,    20'h0);
        inject_req++;
        repeat (3) @(negedge clk);
        check("t5.stray_req",   pram_req,  1'b0);
        check("t5.stray_ready", in_ready,  1'b1);
        check("t5.stray_valid", out_valid, 1'b0);
        wait_cfg = 0;
        send_pixel(px2a, 5'h1F, 5'h09);
        wait_out(lat);
        check_out("t5.next", 20'hA8104, 20'h88030, 15'h1234, 15'h2222, 5'h09);
        accept_out();

        // Backpressure with the next pixel's first beat already waiting.
        send_pixel(px3, 5'h1F, 5'h0A);
        wait_out(lat);
        in_valid   = 1'b1;
        in_layer   = px2a[0];
        in_mask    = 5'h1F;
        in_effects = 5'h0B;
        for (int i = 0; i < 5; i++) begin
            check("t6.in_ready",  in_ready,  1'b0);
            check("t6.out_valid", out_valid, 1'b1);
            check("t6.color0",    color0,    15'h1876);
            check("t6.layer1",    layer1,    20'h88021);
            @(negedge clk);
        end
        accept_out();
        send_pixel(px2a, 5'h1F, 5'h0B);
        wait_out(lat);
        check_out("t6.next", 20'hA8104, 20'h88030, 15'h1234, 15'h2222, 5'h0B);
        accept_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
